// File: rtl/cluster_count_tree.sv
// cluster_count_tree: pipelined VPF popcount with saturated count, threshold overflow and monitor state.
module cluster_count_tree #(
  parameter int NVPF      = 1536,
  parameter int CNT_W     = 8,
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clock4x,
  input  logic                 reset,
  input  logic [NVPF-1:0]      vpfs_i,
  input  logic                 valid_i,
  input  logic [CNT_W-1:0]     thresh_i,
  input  logic                 clear_i,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 valid_o,
  output logic                 overflow_o,
  output logic                 sticky_ovf_o,
  output logic [OVF_CNT_W-1:0] ovf_cnt_o,
  output logic [CNT_W-1:0]     peak_o
);
  localparam int G  = (NVPF + 5) / 6;
  localparam int L  = $clog2(G);
  localparam int FW = $clog2(NVPF + 1);
  localparam int TW = FW < 3 ? 3 : FW;
  localparam int XW = TW > CNT_W ? TW : CNT_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  function automatic logic [2:0] pop6(input logic [5:0] b);
    pop6 = '0;
    for (int j = 0; j < 6; j++) pop6 = pop6 + 3'(b[j]);
  endfunction

  function automatic int n_at(input int k);
    n_at = G;
    for (int j = 0; j < k; j++) n_at = (n_at + 1) / 2;
  endfunction

  logic [6*G-1:0] w_pad;
  logic [6*G-1:0] r_vpf;
  // second half of each level is a zero-filled landing zone for pair reads
  logic [TW-1:0]  r_tree [0:L][0:2*G-1];
  logic [L+1:0]   r_v;

  always_comb begin
    w_pad = '0;
    w_pad[NVPF-1:0] = vpfs_i;
  end

  always_ff @(posedge clock4x) begin
    r_vpf <= w_pad;
    for (int i = 0; i < G; i++) r_tree[0][i] <= TW'(pop6(r_vpf[6*i +: 6]));
    for (int k = 0; k < L; k++)
      for (int i = 0; i < G; i++)
        r_tree[k+1][i] <= (2*i + 1 < n_at(k)) ? r_tree[k][2*i] + r_tree[k][2*i+1] :
                          (2*i < n_at(k))     ? r_tree[k][2*i] : '0;
    for (int k = 0; k <= L; k++)
      for (int i = G; i < 2*G; i++) r_tree[k][i] <= '0;
  end

  logic [XW-1:0]        w_sx;
  logic                 w_v, w_ovf;
  logic [CNT_W-1:0]     w_cnt, w_pk_base, w_pk_new;
  logic [OVF_CNT_W-1:0] w_oc_base;

  assign w_sx      = XW'(r_tree[L][0]);
  assign w_v       = r_v[L+1];
  assign w_cnt     = w_sx > XW'(CMAX) ? CMAX : w_sx[CNT_W-1:0];
  assign w_ovf     = w_v & (w_sx > XW'(thresh_i));
  assign w_oc_base = clear_i ? '0 : ovf_cnt_o;
  assign w_pk_base = clear_i ? '0 : peak_o;
  assign w_pk_new  = w_v ? w_cnt : '0;

  always_ff @(posedge clock4x) begin
    if (reset) begin
      r_v          <= '0;
      valid_o      <= 1'b0;
      cnt_o        <= '0;
      overflow_o   <= 1'b0;
      sticky_ovf_o <= 1'b0;
      ovf_cnt_o    <= '0;
      peak_o       <= '0;
    end else begin
      r_v          <= {r_v[L:0], valid_i};
      valid_o      <= w_v;
      cnt_o        <= w_pk_new;
      overflow_o   <= w_ovf;
      sticky_ovf_o <= (sticky_ovf_o & ~clear_i) | w_ovf;
      ovf_cnt_o    <= (w_ovf && ~&w_oc_base) ? w_oc_base + 1'b1 : w_oc_base;
      peak_o       <= w_pk_new > w_pk_base ? w_pk_new : w_pk_base;
    end
  end
endmodule

// File: tb/tb_cluster_count_tree.sv
// tb_cluster_count_tree: scoreboard bench for the default and odd-width counters.
module tb_cluster_count_tree;
  localparam int LA = 8;
  localparam int LB = 5;

  typedef struct {int cnt; bit ovf; int due;} exp_t;

  logic         clk = 0;
  logic         rst, valid, clr;
  logic [7:0]   thresh;
  logic [1535:0] va;
  logic [99:0]  vb;
  logic [7:0]   cnt_a, peak_a, cnt_b, peak_b;
  logic         valid_a, ovf_a, st_a, valid_b, ovf_b, st_b;
  logic [15:0]  oc_a, oc_b;

  int   checks = 0, errors = 0, cyc = 0;
  bit   chk_en = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  bit   xa, xb, ev;
  int   m_st, m_oc, m_pk, ecnt;

  always #5 clk = ~clk;

  cluster_count_tree #(.NVPF(1536), .CNT_W(8), .OVF_CNT_W(16)) u_a (
    .clock4x(clk), .reset(rst), .vpfs_i(va), .valid_i(valid), .thresh_i(thresh), .clear_i(clr),
    .cnt_o(cnt_a), .valid_o(valid_a), .overflow_o(ovf_a), .sticky_ovf_o(st_a),
    .ovf_cnt_o(oc_a), .peak_o(peak_a));

  cluster_count_tree #(.NVPF(100), .CNT_W(8), .OVF_CNT_W(16)) u_b (
    .clock4x(clk), .reset(rst), .vpfs_i(vb), .valid_i(valid), .thresh_i(thresh), .clear_i(clr),
    .cnt_o(cnt_b), .valid_o(valid_b), .overflow_o(ovf_b), .sticky_ovf_o(st_b),
    .ovf_cnt_o(oc_b), .peak_o(peak_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [1535:0] a, input logic [99:0] b, input bit v, input bit c);
    exp_t e;
    int   p;
    @(negedge clk);
    va = a; vb = b; valid = v; clr = c;
    if (v) begin
      p = $countones(a);
      e.cnt = p > 255 ? 255 : p; e.ovf = p > int'(thresh); e.due = cyc + LA + 3;
      qa.push_back(e);
      p = $countones(b);
      e.cnt = p > 255 ? 255 : p; e.ovf = p > int'(thresh); e.due = cyc + LB + 3;
      qb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, 0, 0);
  endtask

  // reference model advances once per edge, independently of DUT outputs
  always @(posedge clk) begin
    cyc++;
    #1;
    xa = qa.size() != 0 && qa[0].due == cyc;
    xb = qb.size() != 0 && qb[0].due == cyc;
    if (xa) ea = qa.pop_front(); else ea = '{0, 0, 0};
    if (xb) eb = qb.pop_front(); else eb = '{0, 0, 0};
    ecnt = xa ? ea.cnt : 0;
    if (rst) begin
      m_st = 0; m_oc = 0; m_pk = 0; xa = 0; xb = 0; ecnt = 0;
    end else begin
      ev = xa & ea.ovf;
      m_st = (m_st & int'(!clr)) | int'(ev);
      m_oc = (clr ? 0 : m_oc) + int'(ev);
      if (m_oc > 65535) m_oc = 65535;
      m_pk = clr ? 0 : m_pk;
      if (ecnt > m_pk) m_pk = ecnt;
    end
    if (chk_en) begin
      chk("a_valid", 32'(valid_a), 32'(xa));
      chk("a_cnt", 32'(cnt_a), xa ? ea.cnt : 0);
      chk("a_ovf", 32'(ovf_a), 32'(xa & ea.ovf));
      chk("a_sticky", 32'(st_a), m_st);
      chk("a_ovf_cnt", 32'(oc_a), m_oc);
      chk("a_peak", 32'(peak_a), m_pk);
      chk("b_valid", 32'(valid_b), 32'(xb));
      chk("b_cnt", 32'(cnt_b), xb ? eb.cnt : 0);
      chk("b_ovf", 32'(ovf_b), 32'(xb & eb.ovf));
    end
  end

  initial begin
    logic [1535:0] a;
    logic [99:0]   b;
    rst = 1; valid = 0; clr = 0; thresh = 8; va = '0; vb = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      va = {48{$urandom}};
      vb = 100'({$urandom, $urandom, $urandom, $urandom});
      valid = 1;
    end
    @(negedge clk);
    rst = 1; valid = 0; chk_en = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    idle(15);

    a = '0; a[0] = 1; a[700] = 1; a[1535] = 1;
    b = '0; b[99] = 1;
    drive(a, b, 1, 0);
    idle(LA + 3);
    chk("single_peak", 32'(peak_a), 3);

    drive('1, '1, 1, 0);
    idle(LA + 3);
    chk("sat_sticky", 32'(st_a), 1);
    chk("sat_ovf_cnt", 32'(oc_a), 1);
    chk("sat_peak", 32'(peak_a), 255);

    drive('0, '0, 0, 1);
    idle(2);
    for (int n = 0; n <= 20; n++) begin
      a = '0; b = '0;
      for (int j = 0; j < n; j++) begin a[j] = 1; b[j] = 1; end
      drive(a, b, 1, 0);
    end
    idle(LA + 3);
    chk("stream_ovf_cnt", 32'(oc_a), 12);
    chk("stream_peak", 32'(peak_a), 20);
    chk("stream_sticky", 32'(st_a), 1);

    a = '0; b = '0;
    for (int j = 0; j < 10; j++) begin a[j] = 1; b[j] = 1; end
    drive(a, b, 1, 0);
    idle(LA + 1);
    drive('0, '0, 0, 1);
    @(posedge clk); #2;
    chk("coll_valid", 32'(valid_a), 1);
    chk("coll_sticky", 32'(st_a), 1);
    chk("coll_ovf_cnt", 32'(oc_a), 1);
    chk("coll_peak", 32'(peak_a), 10);
    idle(3);
    drive('0, '0, 0, 1);
    @(posedge clk); #2;
    chk("clr_sticky", 32'(st_a), 0);
    chk("clr_ovf_cnt", 32'(oc_a), 0);
    chk("clr_peak", 32'(peak_a), 0);
    idle(LA + 4);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
